// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: arbitrates undefined-instruction and masked external IRQs,
// latches ELR/ESR, holds Exc until acknowledged and blocks nesting until ERET.
module exc_ctrl #(
  parameter int unsigned N    = 64,
  parameter int unsigned NIRQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic            NotAnInstr,
  input  logic            ERet,
  input  logic [N-1:0]    pc_i,
  input  logic [NIRQ-1:0] ExtIRQ,
  input  logic [NIRQ-1:0] IrqMask,
  input  logic            ExcAck,
  output logic            Exc,
  output logic [NIRQ-1:0] ExtlAck,
  output logic [N-1:0]    ELR,
  output logic [3:0]      ESR,
  output logic            InHandler,
  output logic            DoubleFault
);

  typedef enum logic [1:0] {StRun, StTake, StHandler} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    elr_q, elr_d;
  logic [3:0]      esr_q, esr_d;
  logic [NIRQ-1:0] ack_q, ack_d;
  logic            dfault_q, dfault_d;

  logic [NIRQ-1:0] irq_req;
  logic            irq_any;
  logic            undef;
  logic [2:0]      irq_idx;

  assign irq_req = ExtIRQ & ~IrqMask;
  assign irq_any = |irq_req;
  // ERET in decode is never treated as an undefined opcode
  assign undef   = instr_valid & NotAnInstr & ~ERet;

  // Lowest-numbered unmasked line wins
  always_comb begin
    irq_idx = '0;
    for (int k = int'(NIRQ) - 1; k >= 0; k--) begin
      if (irq_req[k]) irq_idx = 3'(k);
    end
  end

  always_comb begin
    state_d  = state_q;
    elr_d    = elr_q;
    esr_d    = esr_q;
    ack_d    = '0;
    dfault_d = dfault_q;
    unique case (state_q)
      StRun: begin
        if (undef) begin
          elr_d   = pc_i;
          esr_d   = 4'b0001;
          state_d = StTake;
        end else if (irq_any) begin
          elr_d   = pc_i;
          esr_d   = {1'b1, irq_idx};
          state_d = StTake;
        end
      end
      StTake: begin
        if (ExcAck) begin
          state_d = StHandler;
          // ESR[3] marks an IRQ cause; its index selects the source to acknowledge
          if (esr_q[3]) ack_d = NIRQ'(1) << esr_q[2:0];
        end
      end
      StHandler: begin
        if (instr_valid && ERet) begin
          state_d = StRun;
        end else if (undef) begin
          dfault_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StRun;
      elr_q    <= '0;
      esr_q    <= '0;
      ack_q    <= '0;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      elr_q    <= elr_d;
      esr_q    <= esr_d;
      ack_q    <= ack_d;
      dfault_q <= dfault_d;
    end
  end

  assign Exc         = (state_q == StTake);
  assign InHandler   = (state_q == StHandler);
  assign ExtlAck     = ack_q;
  assign ELR         = elr_q;
  assign ESR         = esr_q;
  assign DoubleFault = dfault_q;

endmodule
